// File: rtl/hazard_sequencer_pkg.sv
// rtl/hazard_sequencer_pkg.sv - shared types and widths for the hazard sequencer
//
// Purpose: FSM state encoding, register-index width and watchdog counter
// width shared by hazard_sequencer and hazard_watchdog.
// Ports: none (package).
package hazard_sequencer_pkg;

  localparam int REG_W  = 5;
  localparam int WAIT_W = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_watchdog.sv
// rtl/hazard_watchdog.sv - wait-cycle counter with sticky timeout error
//
// Purpose: counts cycles spent waiting on a data-memory access and raises a
// sticky error once the wait reaches TIMEOUT cycles without completion.
// Ports:
//   clk_i   in  clock, rising edge
//   rst_i   in  asynchronous active-high reset
//   en      in  count this cycle (FSM is waiting)
//   clear   in  restart the count (FSM is entering the wait)
//   ready   in  access completes this cycle
//   err     out sticky timeout flag, cleared only by rst_i
import hazard_sequencer_pkg::*;

module hazard_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic clear,
  input  logic ready,
  output logic err
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] SAT   = '1;

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (en && (cnt != SAT)) begin
        cnt <= cnt + 1'b1;
      end
      // The count is 0 in the first waiting cycle, so LIMIT is hit in the
      // TIMEOUT-th waiting cycle; the flag is visible from the next one.
      if (en && !ready && (cnt >= LIMIT)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline stall/bubble/flush controller with memory-wait freeze
//
// Purpose: decides PC/IF-ID write enables, ID/EX bubble, IF/ID flush and
// whole-pipeline freeze for the 5-stage core. Priority: freeze > load-use > flush.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall and flush counters).
// Ports:
//   clk_i, rst_i          clock (rising) and async active-high reset
//   IF_ID_Rs1_i/Rs2_i     source registers of the instruction in ID
//   ID_EX_MemRead_i/Rd_i  load flag and destination of the instruction in EX
//   Branch_taken_i        branch/jump in ID resolved taken
//   dmem_req_i            MEM stage issues a data-memory access
//   dmem_ready_i          data memory completes the access
//   PCWrite_o, IF_ID_Write_o, NoOp_o, IF_ID_Flush_o, freeze_o  control outputs
//   err_o                 sticky watchdog error
//   stall_cnt_o, flush_cnt_o  perf counters (HAZARD_PERF_CNT_EN only)
import hazard_sequencer_pkg::*;

module hazard_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] IF_ID_Rs1_i,
  input  logic [REG_W-1:0] IF_ID_Rs2_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [REG_W-1:0] ID_EX_Rd_i,
  input  logic             Branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             NoOp_o,
  output logic             IF_ID_Flush_o,
  output logic             freeze_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      flush_cnt_o,
`endif
  output logic             err_o
);

  state_t state, state_next;
  logic   load_use;
  logic   wait_entry;

  assign load_use = ID_EX_MemRead_i && (ID_EX_Rd_i != '0) &&
                    ((ID_EX_Rd_i == IF_ID_Rs1_i) || (ID_EX_Rd_i == IF_ID_Rs2_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    freeze_o      = 1'b0;
    PCWrite_o     = 1'b1;
    IF_ID_Write_o = 1'b1;
    NoOp_o        = 1'b0;
    IF_ID_Flush_o = 1'b0;
    wait_entry    = 1'b0;

    case (state)
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          freeze_o   = 1'b1;
          wait_entry = 1'b1;
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_next = RUN;
        end else begin
          freeze_o = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (freeze_o) begin
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
    end else if (load_use) begin
      // A taken branch here is dropped; it is still asserted next cycle
      // once the bubble has removed the load from EX.
      PCWrite_o     = 1'b0;
      IF_ID_Write_o = 1'b0;
      NoOp_o        = 1'b1;
    end else if (Branch_taken_i) begin
      IF_ID_Flush_o = 1'b1;
    end
  end

  hazard_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (state == MEM_WAIT),
    .clear (wait_entry),
    .ready (dmem_ready_i),
    .err   (err_o)
  );

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!PCWrite_o) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (IF_ID_Flush_o) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       memread, branch, req, ready;
  logic       pcw, ifw, noop, flush, freeze, err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(
    .TIMEOUT(4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .IF_ID_Rs1_i     (rs1),
    .IF_ID_Rs2_i     (rs2),
    .ID_EX_MemRead_i (memread),
    .ID_EX_Rd_i      (rd),
    .Branch_taken_i  (branch),
    .dmem_req_i      (req),
    .dmem_ready_i    (ready),
    .PCWrite_o       (pcw),
    .IF_ID_Write_o   (ifw),
    .NoOp_o          (noop),
    .IF_ID_Flush_o   (flush),
    .freeze_o        (freeze),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt),
`endif
    .err_o           (err)
  );

  // Expected vector order: {PCWrite, IF_ID_Write, NoOp, Flush, freeze, err}
  localparam logic [5:0] NORMAL  = 6'b110000;
  localparam logic [5:0] BUBBLE  = 6'b001000;
  localparam logic [5:0] FLUSHV  = 6'b110100;
  localparam logic [5:0] FROZEN  = 6'b000010;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [5:0] exp);
    #1;
    check(tag, {26'd0, pcw, ifw, noop, flush, freeze, err}, {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0;
    memread = 1'b0; branch = 1'b0; req = 1'b0; ready = 1'b0;
    tick();
    check_out("reset_idle", NORMAL);
    req = 1'b1;
    check_out("reset_run_rule_freeze", FROZEN);
    tick();
    req = 1'b0;
    check_out("reset_holds_run", NORMAL);
    rst = 1'b0;
    tick();

    // Load-use on rs2, bubble clears it next cycle
    memread = 1'b1; rd = 5'd5; rs2 = 5'd5;
    check_out("load_use_rs2", BUBBLE);
    tick();
    memread = 1'b0;
    check_out("load_use_one_cycle", NORMAL);
    memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    check_out("load_use_rd0", NORMAL);
    rd = 5'd7; rs1 = 5'd7; rs2 = 5'd3;
    check_out("load_use_rs1", BUBBLE);
    rs1 = 5'd8;
    check_out("load_no_match", NORMAL);

    // Branch during load-use is held off one cycle
    rs1 = 5'd7; branch = 1'b1;
    check_out("branch_under_load_use", BUBBLE);
    tick();
    memread = 1'b0;
    check_out("branch_after_bubble", FLUSHV);
    tick();
    branch = 1'b0;

    // Memory wait: 3 frozen cycles
    req = 1'b1; ready = 1'b0;
    check_out("mem_entry", FROZEN);
    tick();
    req = 1'b0;
    memread = 1'b1; rd = 5'd7; branch = 1'b1;
    check_out("mem_wait1_priority", FROZEN);
    memread = 1'b0; branch = 1'b0;
    tick();
    check_out("mem_wait2", FROZEN);
    tick();
    ready = 1'b1;
    check_out("mem_ready_unfreeze", NORMAL);
    tick();
    ready = 1'b0;
    check_out("mem_back_in_run", NORMAL);

    // Watchdog with TIMEOUT=4
    req = 1'b1;
    check_out("wd_entry", FROZEN);
    tick();
    req = 1'b0;
    check_out("wd_mw1", FROZEN);
    tick();
    tick();
    tick();
    check_out("wd_mw4_no_err_yet", FROZEN);
    tick();
    check_out("wd_err_set", 6'b000011);
    ready = 1'b1;
    check_out("wd_ready_err_sticky", 6'b110001);
    tick();
    ready = 1'b0;
    check_out("wd_err_still_set", 6'b110001);

    // Reset in the middle of a wait
    req = 1'b1;
    check_out("rst_mid_entry", 6'b000011);
    tick();
    req = 1'b0;
    check_out("rst_mid_waiting", 6'b000011);
    rst = 1'b1;
    check_out("rst_mid_async", NORMAL);
    #1;
    rst = 1'b0;
    tick();
    check_out("rst_mid_after", NORMAL);

    // Fresh access in the cycle right after a wait exit
    req = 1'b1;
    tick();
    ready = 1'b1;
    check_out("fresh_exit", NORMAL);
    tick();
    ready = 1'b0;
    check_out("fresh_new_req", FROZEN);
    tick();
    ready = 1'b1; req = 1'b0;
    check_out("fresh_done", NORMAL);
    tick();
    ready = 1'b0;

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1;
    #1;
    check("perf_reset_stall", stall_cnt, 32'd0);
    check("perf_reset_flush", flush_cnt, 32'd0);
    rst = 1'b0;
    tick();
    memread = 1'b1; rd = 5'd9; rs1 = 5'd9;
    tick();
    tick();
    memread = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0; branch = 1'b1;
    tick();
    branch = 1'b0;
    #1;
    check("perf_stall_cnt", stall_cnt, 32'd5);
    check("perf_flush_cnt", flush_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the forwarding logic and decides when the front end stalls, when a bubble is injected into ID/EX, and when IF/ID is flushed. Inputs are load-use hazards, taken branches resolved in ID, and multi-cycle data-memory accesses. A small FSM freezes the whole pipeline while a data-memory access is outstanding, with a watchdog that flags a hung access.

## Interface
Parameters:
- TIMEOUT, 64: max cycles in MEM_WAIT before err_o is set; legal range 2..255.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- IF_ID_Rs1_i  in  5  rs1 of instruction in ID
- IF_ID_Rs2_i  in  5  rs2 of instruction in ID
- ID_EX_MemRead_i  in  1  instruction in EX is a load
- ID_EX_Rd_i  in  5  rd of instruction in EX
- Branch_taken_i  in  1  branch/jump in ID resolved taken
- dmem_req_i  in  1  MEM stage issuing a data-memory access this cycle
- dmem_ready_i  in  1  data memory completes the access this cycle
- PCWrite_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID register write enable
- NoOp_o  out  1  zero ID/EX control (bubble)
- IF_ID_Flush_o  out  1  clear IF/ID to NOP
- freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- err_o  out  1  sticky watchdog error
- stall_cnt_o  out  32  stall-cycle counter (only with HAZARD_PERF_CNT_EN)
- flush_cnt_o  out  32  flush counter (only with HAZARD_PERF_CNT_EN)

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- Memory hazard:
  - In RUN, when dmem_req_i=1 and dmem_ready_i=0, freeze the pipeline and move to MEM_WAIT.
  - In MEM_WAIT, return to RUN when dmem_ready_i=1.
- freeze = (dmem_req_i & !dmem_ready_i) in RUN; (!dmem_ready_i) in MEM_WAIT.
- Load-use hazard: ID_EX_MemRead_i & (ID_EX_Rd_i != 0) & (ID_EX_Rd_i == IF_ID_Rs1_i | ID_EX_Rd_i == IF_ID_Rs2_i).
- Priority is freeze > load-use > flush:
  - freeze: freeze_o=1, PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=0, IF_ID_Flush_o=0.
  - load-use (no freeze): PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1, IF_ID_Flush_o=0. A concurrent Branch_taken_i is ignored and re-evaluated next cycle.
  - flush (Branch_taken_i, no freeze, no load-use): IF_ID_Flush_o=1, PCWrite_o=1, IF_ID_Write_o=1.
  - otherwise: PCWrite_o=1, IF_ID_Write_o=1, all other outputs 0.
- Watchdog: 8-bit wait counter.
  - Cleared on entering MEM_WAIT; increments each cycle in MEM_WAIT, saturating at 255.
  - When it reaches TIMEOUT-1 with dmem_ready_i=0, err_o is set. err_o stays set until rst_i; the FSM keeps waiting.
- A new dmem_req_i in the cycle after MEM_WAIT exits is a fresh access and follows the RUN rule.

## Timing
- All control outputs are combinational from the registered state plus current inputs: zero-cycle latency.
- State, wait counter, err_o and the perf counters are registered on the rising edge of clk_i.
- On rst_i high, asynchronously: state=RUN, wait counter=0, err_o=0, both perf counters=0.
  - While rst_i is high, the combinational outputs still follow the RUN rules for the current inputs.
  - Reset asserted in MEM_WAIT abandons the wait; the next cycle is RUN.
- Load-use with a single-cycle load lasts exactly 1 cycle, because the bubble clears ID_EX_MemRead_i.
- MEM_WAIT exit: freeze_o drops in the same cycle dmem_ready_i=1; the state is RUN at the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o increments every cycle that PCWrite_o=0.
  - flush_cnt_o increments every cycle that IF_ID_Flush_o=1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- HAZARD_PERF_CNT_EN undefined: both ports and both counters are absent.

## Structure
- Shared package: FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1), register-index width (5), wait-counter width (8).
- One sub-module, hazard_watchdog: wait counter plus sticky err_o, with enable = (state==MEM_WAIT) and clear = entry into MEM_WAIT.

## Test plan
- Load-use: ID_EX_MemRead_i=1, ID_EX_Rd_i=5, IF_ID_Rs2_i=5 -> PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1 for 1 cycle. With Rd=0 -> no stall.
- Branch during load-use: same hazard plus Branch_taken_i=1 -> IF_ID_Flush_o=0. Next cycle (hazard gone, branch still 1) -> IF_ID_Flush_o=1.
- Memory wait: dmem_req_i=1, dmem_ready_i low for 3 cycles then high -> freeze_o=1 for exactly 3 cycles; FSM back in RUN on the following edge.
- Watchdog: TIMEOUT=4, dmem_ready_i held 0 -> err_o rises after the 4th MEM_WAIT cycle and stays 1 after ready arrives, until rst_i.
- Reset mid-wait: rst_i pulsed in MEM_WAIT -> state RUN, err_o=0; dmem_req_i=0 afterwards -> freeze_o=0.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 3 freeze cycles + 1 flush -> stall_cnt_o=5, flush_cnt_o=1.
